// File: rtl/machine_check_pipe.sv
// Single-stage result checker: validates word tags and result-slot ordering,
// packs accepted results and keeps a saturating record of rejected beats.
module machine_check_pipe #(
  parameter int VW  = 63,
  parameter int NR  = 2,
  parameter int NW  = 2,
  parameter int WW  = 95,
  parameter int FCW = 16,
  localparam int CW = $clog2(NR + 1),
  localparam int DW = CW + NR * VW
) (
  input  logic                   system1000,
  input  logic                   system1000_rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NW*WW-1:0]       in_words,
  input  logic [NR*(VW+2)-1:0]   in_results,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_ok,
  output logic [DW-1:0]          out_data,
  input  logic                   clear_faults,
  output logic [FCW-1:0]         fault_count,
  output logic [1:0]             last_cause
);

  logic          word_fault;
  logic          res_error;
  logic          order_gap;
  logic          seen_empty;
  logic          beat_ok;
  logic          accept;
  logic          reject;
  logic [1:0]    cause;
  logic [1:0]    rtag;
  logic [VW-1:0] rval;
  logic [CW-1:0] valid_cnt;
  logic [DW-1:0] beat_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign reject   = accept && !beat_ok;

  // Channel 0 sits in the most significant slice of both the input and output buses.
  always_comb begin
    word_fault = 1'b0;
    res_error  = 1'b0;
    order_gap  = 1'b0;
    seen_empty = 1'b0;
    valid_cnt  = '0;
    beat_data  = '0;
    rtag       = '0;
    rval       = '0;
    for (int w = 0; w < NW; w++) begin
      if (in_words[(NW-w)*WW-1 -: 2] == 2'b01) word_fault = 1'b1;
    end
    for (int r = 0; r < NR; r++) begin
      rtag = in_results[(NR-r)*(VW+2)-1 -: 2];
      rval = in_results[(NR-1-r)*(VW+2) +: VW];
      if (rtag == 2'b01) begin
        res_error = 1'b1;
      end else if (rtag == 2'b00) begin
        seen_empty = 1'b1;
      end else begin
        if (seen_empty) order_gap = 1'b1;
        valid_cnt = valid_cnt + CW'(1);
        beat_data[(NR-1-r)*VW +: VW] = rval;
      end
    end
    beat_data[DW-1 -: CW] = valid_cnt;
  end

  // Rejection cause with fixed priority: word fault, then result error, then gap.
  always_comb begin
    cause = 2'b00;
    if (word_fault)      cause = 2'b01;
    else if (res_error)  cause = 2'b10;
    else if (order_gap)  cause = 2'b11;
    beat_ok = (cause == 2'b00);
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      out_valid <= 1'b0;
      out_ok    <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ok    <= beat_ok;
      out_data  <= beat_ok ? beat_data : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A clear coinciding with a rejected beat leaves exactly that one rejection recorded.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      fault_count <= '0;
      last_cause  <= 2'b00;
    end else if (clear_faults) begin
      fault_count <= reject ? FCW'(1) : '0;
      last_cause  <= reject ? cause : 2'b00;
    end else if (reject) begin
      fault_count <= (fault_count == '1) ? fault_count : fault_count + FCW'(1);
      last_cause  <= cause;
    end
  end

endmodule
